// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two clients share one RAM port with round-robin grant,
// a registered command stage and a two-cycle tagged read-return pipeline.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  c0_req,
    input  logic                  c0_wr,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    input  logic [17:0]           c0_wdata,
    output logic                  c0_gnt,
    output logic                  c0_rvalid,
    output logic [17:0]           c0_rdata,
    input  logic                  c1_req,
    input  logic                  c1_wr,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    input  logic [17:0]           c1_wdata,
    output logic                  c1_gnt,
    output logic                  c1_rvalid,
    output logic [17:0]           c1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [17:0]           ram_data,
    output logic                  ram_wren,
    input  logic [17:0]           ram_q
);
    logic                  ptr, acc, win, sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [17:0]           sel_data;
    logic                  s1_valid, s1_rd, s1_id, s2_valid, s2_rd, s2_id;
    always_comb begin
        c0_gnt   = !reset && c0_req && (!c1_req || !ptr);
        c1_gnt   = !reset && c1_req && (!c0_req || ptr);
        acc      = c0_gnt || c1_gnt;
        win      = c1_gnt;
        sel_wr   = win ? c1_wr : c0_wr;
        sel_addr = win ? c1_addr : c0_addr;
        sel_data = win ? c1_wdata : c0_wdata;
    end
    // s1 tracks the command presented to the RAM, s2 the cycle its ram_q is valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr         <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            s1_valid    <= 1'b0;
            s1_rd       <= 1'b0;
            s1_id       <= 1'b0;
            s2_valid    <= 1'b0;
            s2_rd       <= 1'b0;
            s2_id       <= 1'b0;
            c0_rvalid   <= 1'b0;
            c1_rvalid   <= 1'b0;
            c0_rdata    <= '0;
            c1_rdata    <= '0;
        end else begin
            if (acc) begin
                ptr         <= !win;
                ram_address <= sel_addr;
                ram_data    <= sel_data;
            end
            ram_wren  <= acc && sel_wr;
            s1_valid  <= acc;
            s1_rd     <= !sel_wr;
            s1_id     <= win;
            s2_valid  <= s1_valid;
            s2_rd     <= s1_rd;
            s2_id     <= s1_id;
            c0_rvalid <= s2_valid && s2_rd && !s2_id;
            c1_rvalid <= s2_valid && s2_rd && s2_id;
            if (s2_valid && s2_rd && !s2_id)
                c0_rdata <= ram_q;
            if (s2_valid && s2_rd && s2_id)
                c1_rdata <= ram_q;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table-driven grant vectors, directed corner sequences and
// random traffic checked against a memory/queue reference model.
module tb_ram_port_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        c0_req = 0, c0_wr = 0, c1_req = 0, c1_wr = 0;
    logic [3:0]  c0_addr = 0, c1_addr = 0;
    logic [17:0] c0_wdata = 0, c1_wdata = 0;
    logic        c0_gnt, c0_rvalid, c1_gnt, c1_rvalid, ram_wren;
    logic [17:0] c0_rdata, c1_rdata, ram_data;
    logic [17:0] ram_q = 0;
    logic [3:0]  ram_address;

    ram_port_arbiter #(.ADDR_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .c0_req(c0_req), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM attached to port A
    logic [17:0] ram [16] = '{default: 18'h0};
    always @(posedge clock) begin
        if (ram_wren) ram[ram_address] <= ram_data;
        ram_q <= ram[ram_address];
    end

    typedef struct {bit req; bit wr; logic [3:0] a; logic [17:0] d;} op_t;
    typedef struct {op_t o0; op_t o1; logic [1:0] eg;} vec_t;
    typedef struct {bit id; logic [17:0] d; int due;} rd_t;

    int          vectors = 0, miscompares = 0, cyc = 0;
    bit          mptr = 0;
    logic [17:0] mem [16] = '{default: 18'h0};
    logic [17:0] last [2] = '{18'h0, 18'h0};
    rd_t         q [$];
    vec_t        tbl [12];
    logic [1:0]  dg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic op_t wr_op(input logic [3:0] a, input logic [17:0] d);
        return '{1'b1, 1'b1, a, d};
    endfunction
    function automatic op_t rd_op(input logic [3:0] a);
        return '{1'b1, 1'b0, a, 18'h3ffff};
    endfunction
    function automatic op_t idle_op();
        return '{1'b0, 1'b0, 4'h0, 18'h0};
    endfunction

    // One clock cycle: drive at negedge, check grants, model acceptance, check returns
    task automatic tick(input op_t o0, input op_t o1, output logic [1:0] g);
        bit   any, id;
        op_t  w;
        logic rv;
        logic [17:0] rd;
        c0_req = o0.req; c0_wr = o0.wr; c0_addr = o0.a; c0_wdata = o0.d;
        c1_req = o1.req; c1_wr = o1.wr; c1_addr = o1.a; c1_wdata = o1.d;
        any = o0.req || o1.req;
        id  = (o0.req && o1.req) ? mptr : o1.req;
        #1;
        g = {c0_gnt, c1_gnt};
        chk("gnt", g, any ? (id ? 2'b01 : 2'b10) : 2'b00);
        @(posedge clock);
        if (any) begin
            w = id ? o1 : o0;
            if (w.wr) mem[w.a] = w.d;
            else q.push_back('{id, mem[w.a], cyc + 3});
            mptr = !id;
        end
        @(negedge clock);
        cyc++;
        for (int n = 0; n < 2; n++) begin
            bit exp;
            rv  = n ? c1_rvalid : c0_rvalid;
            rd  = n ? c1_rdata : c0_rdata;
            exp = q.size() > 0 && q[0].due == cyc && q[0].id == 1'(n);
            if (exp) last[n] = q[0].d;
            chk(n ? "c1_rvalid" : "c0_rvalid", rv, exp);
            chk(n ? "c1_rdata" : "c0_rdata", rd, last[n]);
            if (exp) void'(q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(idle_op(), idle_op(), dg);
    endtask

    initial begin
        tbl[0]  = '{wr_op(0, 18'h00101), wr_op(8,  18'h10001), 2'b10};
        tbl[1]  = '{wr_op(1, 18'h00202), wr_op(9,  18'h10002), 2'b01};
        tbl[2]  = '{idle_op(),           wr_op(10, 18'h10003), 2'b01};
        tbl[3]  = '{idle_op(),           wr_op(11, 18'h10004), 2'b01};
        tbl[4]  = '{idle_op(),           wr_op(12, 18'h10005), 2'b01};
        tbl[5]  = '{wr_op(2, 18'h00303), wr_op(13, 18'h10006), 2'b10};
        tbl[6]  = '{idle_op(),           idle_op(),            2'b00};
        tbl[7]  = '{wr_op(4, 18'h00404), wr_op(14, 18'h10007), 2'b01};
        tbl[8]  = '{wr_op(5, 18'h00505), idle_op(),            2'b10};
        tbl[9]  = '{wr_op(6, 18'h00606), idle_op(),            2'b10};
        tbl[10] = '{wr_op(7, 18'h00707), wr_op(15, 18'h10008), 2'b01};
        tbl[11] = '{wr_op(3, 18'h00808), wr_op(15, 18'h10009), 2'b10};

        c0_req = 1; c1_req = 1;
        @(posedge clock);
        @(negedge clock);
        chk("rst_gnt", {c0_gnt, c1_gnt}, 2'b00);
        chk("rst_wren", ram_wren, 1'b0);
        chk("rst_addr", ram_address, 4'h0);
        chk("rst_data", ram_data, 18'h0);
        chk("rst_rvalid", {c0_rvalid, c1_rvalid}, 2'b00);
        chk("rst_rdata", {c0_rdata, c1_rdata}, 36'h0);
        reset = 0;

        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].o0, tbl[i].o1, dg);
            chk($sformatf("tbl_gnt[%0d]", i), dg, tbl[i].eg);
        end
        idle(3);

        // Write then read same address from client 0
        tick(wr_op(3, 18'h2AAAA), idle_op(), dg);
        tick(rd_op(3), idle_op(), dg);
        idle(3);
        chk("c0_rdata_2aaaa", c0_rdata, 18'h2AAAA);

        // Contention: strict alternation of reads
        tick(wr_op(1, 18'h11111), idle_op(), dg);
        tick(idle_op(), wr_op(2, 18'h22222), dg);
        for (int i = 0; i < 6; i++) begin
            tick(rd_op(1), rd_op(2), dg);
            chk("alt_gnt", dg, (i % 2) ? 2'b01 : 2'b10);
        end
        idle(3);

        // c1 write followed next cycle by c0 read of the same address
        tick(idle_op(), wr_op(7, 18'h00055), dg);
        tick(rd_op(7), idle_op(), dg);
        idle(3);
        chk("c0_rdata_55", c0_rdata, 18'h00055);

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            op_t r0, r1;
            r0 = '{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 18'($urandom)};
            r1 = '{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 18'($urandom)};
            tick(r0, r1, dg);
        end
        idle(4);
        chk("queue_drained", q.size(), 0);

        // Reset with a c0 read in flight
        tick(rd_op(5), idle_op(), dg);
        c0_req = 1; c1_req = 1;
        #2 reset = 1;
        #1;
        chk("arst_addr", ram_address, 4'h0);
        chk("arst_data", ram_data, 18'h0);
        chk("arst_wren", ram_wren, 1'b0);
        chk("arst_gnt", {c0_gnt, c1_gnt}, 2'b00);
        chk("arst_rdata", {c0_rdata, c1_rdata}, 36'h0);
        @(posedge clock);
        @(negedge clock);
        chk("arst_rvalid", {c0_rvalid, c1_rvalid}, 2'b00);
        chk("arst_gnt_hold", {c0_gnt, c1_gnt}, 2'b00);
        reset = 0;
        q.delete();
        mptr = 0;
        last = '{18'h0, 18'h0};
        idle(3);
        tick(rd_op(4), rd_op(6), dg);
        chk("post_rst_gnt", dg, 2'b10);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL set the RAM address width; data width SHALL be fixed at 18 bits.
REQ-002 clock  input  1  single clock; all state SHALL update on posedge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 c0_req  input  1  client 0 access request.
REQ-005 c0_wr  input  1  client 0 operation: 1 = write, 0 = read.
REQ-006 c0_addr  input  ADDR_WIDTH  client 0 word address.
REQ-007 c0_wdata  input  18  client 0 write data.
REQ-008 c0_gnt  output  1  client 0 request accepted this cycle (combinational).
REQ-009 c0_rvalid  output  1  client 0 read data valid, one-cycle pulse.
REQ-010 c0_rdata  output  18  client 0 read data.
REQ-011 c1_req, c1_wr, c1_addr, c1_wdata, c1_gnt, c1_rvalid, c1_rdata SHALL mirror REQ-004..REQ-010 for client 1.
REQ-012 ram_address  output  ADDR_WIDTH  registered address to RAM port A.
REQ-013 ram_data  output  18  registered write data to RAM port A.
REQ-014 ram_wren  output  1  registered write enable to RAM port A.
REQ-015 ram_q  input  18  RAM port A read data; valid during the cycle after the RAM samples its inputs.

Function
REQ-016 The block SHALL share one RAM port between two clients, accepting at most one operation per cycle, fully pipelined (no busy cycles).
REQ-017 Acceptance SHALL occur at a posedge where cN_req and cN_gnt are both high.
REQ-018 Grant SHALL be combinational from req and a 1-bit priority pointer ptr: only one requester -> that one is granted; both requesting -> client ptr is granted; none -> no grant.
REQ-019 c0_gnt and c1_gnt SHALL never be high together and SHALL be low when the corresponding req is low.
REQ-020 After each acceptance, ptr SHALL be set to the other client; with no acceptance, ptr SHALL hold.
REQ-021 Stage 1: on acceptance at edge E, ram_address, ram_data and ram_wren SHALL be loaded from the winner's addr, wdata and wr; with no acceptance, ram_wren SHALL load 0 and ram_address/ram_data SHALL hold.
REQ-022 The stage-1 tag (valid, is_read, client id) SHALL advance one stage per cycle alongside the command.
REQ-023 Stage 2: at edge E+2, for an accepted read, ram_q SHALL be captured into the owning client's cN_rdata, and cN_rvalid SHALL be high for exactly the cycle following E+2.
REQ-024 Read latency SHALL be exactly 2 cycles from acceptance to rvalid; writes SHALL produce no rvalid.
REQ-025 cN_rdata SHALL hold its last captured value while cN_rvalid is low.
REQ-026 Back-to-back reads SHALL yield one rvalid per accepted read, in acceptance order, with no drops.
REQ-027 A write accepted at E followed by a read of the same address accepted at E+1 SHALL return the newly written data.
REQ-028 Both clients requesting continuously SHALL be granted strictly alternately.

Reset
REQ-029 On reset assertion, independent of clock: ptr = 0; ram_wren = 0; ram_address = 0; ram_data = 0; both pipeline tags invalid; c0_rvalid = c1_rvalid = 0; c0_rdata = c1_rdata = 0.
REQ-030 Reads in flight at reset SHALL be discarded and SHALL never produce rvalid after reset deasserts.
REQ-031 While reset is high, c0_gnt and c1_gnt SHALL be 0 and no acceptance SHALL occur.

Verification
REQ-032 After reset, c0 writes 0x2AAAA to addr 3, then c0 reads addr 3 -> c0_rvalid pulses 2 cycles after read acceptance with c0_rdata = 0x2AAAA; c1_rvalid stays 0.
REQ-033 c0 and c1 both hold req high for 6 cycles with reads of addrs 1 and 2 -> grants c0,c1,c0,c1,c0,c1; rvalids alternate with the matching data.
REQ-034 Only c1 requesting for 3 consecutive cycles (ptr = 0) -> c1 granted every cycle; ptr = 0 afterwards.
REQ-035 c1 writes 0x00055 to addr 7 at E, c0 reads addr 7 at E+1 -> c0_rdata = 0x00055 at E+3.
REQ-036 Reset asserted mid-cycle one cycle after a c0 read is accepted -> outputs clear immediately; no c0_rvalid pulse after release; first post-reset contention grants c0.
REQ-037 Random mixed traffic against a reference memory model -> every rvalid's data matches the model; gnt is never high for both clients together.
